// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - SPU shared encodings, sizes and the even-pipe issue bundle
package spu_pkg;

   localparam int REG_COUNT = 128;
   localparam int DATA_W    = 128;
   localparam int ADDR_W    = 7;

   localparam logic [0:10] NOP_OP = 11'd0;

   typedef enum logic [1:0] {
      UNIT_FP   = 2'd0,
      UNIT_FX2  = 2'd1,
      UNIT_BYTE = 2'd2,
      UNIT_FX1  = 2'd3
   } unit_t;

   typedef struct packed {
      logic [0:10]       op;
      logic [2:0]        format;
      logic [1:0]        unit;
      logic [0:6]        rt_addr;
      logic [0:DATA_W-1] ra;
      logic [0:DATA_W-1] rb;
      logic [0:DATA_W-1] rc;
      logic [0:17]       imm;
      logic              reg_write;
   } issue_t;

endpackage

// File: rtl/reg_file_2w3r.sv
// rtl/reg_file_2w3r.sv - 128x128 register file, two write ports, three read ports
// Same-cycle write forwarding into reads only when RF_WB_BYPASS_EN is defined.
module reg_file_2w3r
   import spu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we_even,
   input  logic [0:6]        waddr_even,
   input  logic [0:DATA_W-1] wdata_even,
   input  logic              we_odd,
   input  logic [0:6]        waddr_odd,
   input  logic [0:DATA_W-1] wdata_odd,
   input  logic [0:6]        raddr_a,
   input  logic [0:6]        raddr_b,
   input  logic [0:6]        raddr_c,
   output logic [0:DATA_W-1] rdata_a,
   output logic [0:DATA_W-1] rdata_b,
   output logic [0:DATA_W-1] rdata_c
);

   logic [0:DATA_W-1] mem [REG_COUNT];
   logic              byp_en;

`ifdef RF_WB_BYPASS_EN
   assign byp_en = 1'b1;
`else
   assign byp_en = 1'b0;
`endif

   // Even port is written last so it wins an address collision with odd.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
      end else begin
         if (we_odd)  mem[waddr_odd]  <= wdata_odd;
         if (we_even) mem[waddr_even] <= wdata_even;
      end
   end

   function automatic logic [0:DATA_W-1] rd(input logic [0:6] a);
      if (byp_en && we_even && a == waddr_even) return wdata_even;
      if (byp_en && we_odd && a == waddr_odd)   return wdata_odd;
      return mem[a];
   endfunction

   always_comb begin
      rdata_a = rd(raddr_a);
      rdata_b = rd(raddr_b);
      rdata_c = rd(raddr_c);
   end

endmodule

// File: rtl/reg_fetch_even.sv
// rtl/reg_fetch_even.sv - even-pipe register fetch / issue with RAW scoreboard
// RF_WB_BYPASS_EN: forward same-cycle writeback and skip the writeback slot in hazard checks.
module reg_fetch_even
   import spu_pkg::*;
#(
   parameter int DEPTH = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_dec,
   input  logic [0:10]       op_dec,
   input  logic [2:0]        format_dec,
   input  logic [1:0]        unit_dec,
   input  logic [0:17]       imm_dec,
   input  logic [0:6]        rt_addr_dec,
   input  logic [0:6]        ra_addr_dec,
   input  logic [0:6]        rb_addr_dec,
   input  logic [0:6]        rc_addr_dec,
   input  logic              ra_use_dec,
   input  logic              rb_use_dec,
   input  logic              rc_use_dec,
   input  logic              reg_write_dec,
   output logic              stall,
   output logic [0:10]       op,
   output logic [2:0]        format,
   output logic [1:0]        unit,
   output logic [0:6]        rt_addr,
   output logic [0:DATA_W-1] ra,
   output logic [0:DATA_W-1] rb,
   output logic [0:DATA_W-1] rc,
   output logic [0:17]       imm,
   output logic              reg_write,
   input  logic [0:DATA_W-1] rt_wb,
   input  logic [0:6]        rt_addr_wb,
   input  logic              reg_write_wb,
   input  logic [0:DATA_W-1] rt_wb_odd,
   input  logic [0:6]        rt_addr_wb_odd,
   input  logic              reg_write_wb_odd
);

`ifdef RF_WB_BYPASS_EN
   localparam int CHECK_SLOTS = DEPTH - 1;
`else
   localparam int CHECK_SLOTS = DEPTH;
`endif

   logic [0:6]        sb_addr [DEPTH];
   logic              sb_wr   [DEPTH];
   logic              hazard;
   logic              issue;
   logic [0:DATA_W-1] rd_a, rd_b, rd_c;
   issue_t            nxt, q;

   reg_file_2w3r u_rf (
      .clk        (clk),
      .reset      (reset),
      .we_even    (reg_write_wb),
      .waddr_even (rt_addr_wb),
      .wdata_even (rt_wb),
      .we_odd     (reg_write_wb_odd),
      .waddr_odd  (rt_addr_wb_odd),
      .wdata_odd  (rt_wb_odd),
      .raddr_a    (ra_addr_dec),
      .raddr_b    (rb_addr_dec),
      .raddr_c    (rc_addr_dec),
      .rdata_a    (rd_a),
      .rdata_b    (rd_b),
      .rdata_c    (rd_c)
   );

   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < CHECK_SLOTS; i++) begin
         if (sb_wr[i] && ((ra_use_dec && ra_addr_dec == sb_addr[i]) ||
                          (rb_use_dec && rb_addr_dec == sb_addr[i]) ||
                          (rc_use_dec && rc_addr_dec == sb_addr[i])))
            hazard = 1'b1;
      end
   end

   assign stall = valid_dec & hazard;
   assign issue = valid_dec & ~hazard;

   always_comb begin
      nxt    = '0;
      nxt.op = NOP_OP;
      if (issue) begin
         nxt.op        = op_dec;
         nxt.format    = format_dec;
         nxt.unit      = unit_dec;
         nxt.rt_addr   = rt_addr_dec;
         nxt.ra        = rd_a;
         nxt.rb        = rd_b;
         nxt.rc        = rd_c;
         nxt.imm       = imm_dec;
         nxt.reg_write = reg_write_dec;
      end
   end

   // A NOP bundle carries reg_write=0, so it enters the scoreboard as a bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            sb_addr[i] <= '0;
            sb_wr[i]   <= 1'b0;
         end
      end else begin
         q          <= nxt;
         sb_addr[0] <= nxt.rt_addr;
         sb_wr[0]   <= nxt.reg_write;
         for (int i = 1; i < DEPTH; i++) begin
            sb_addr[i] <= sb_addr[i-1];
            sb_wr[i]   <= sb_wr[i-1];
         end
      end
   end

   assign op        = q.op;
   assign format    = q.format;
   assign unit      = q.unit;
   assign rt_addr   = q.rt_addr;
   assign ra        = q.ra;
   assign rb        = q.rb;
   assign rc        = q.rc;
   assign imm       = q.imm;
   assign reg_write = q.reg_write;

endmodule

// File: tb/tb_reg_fetch_even.sv
// tb/tb_reg_fetch_even.sv - directed and randomized bench for reg_fetch_even
module tb_reg_fetch_even;

   localparam int DEPTH = 7;
`ifdef RF_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         valid_dec;
   logic [10:0]  op_dec;
   logic [2:0]   format_dec;
   logic [1:0]   unit_dec;
   logic [17:0]  imm_dec;
   logic [6:0]   rt_addr_dec, ra_addr_dec, rb_addr_dec, rc_addr_dec;
   logic         ra_use_dec, rb_use_dec, rc_use_dec, reg_write_dec;
   logic         stall;
   logic [10:0]  op;
   logic [2:0]   format;
   logic [1:0]   unit;
   logic [6:0]   rt_addr;
   logic [127:0] ra, rb, rc;
   logic [17:0]  imm;
   logic         reg_write;
   logic [127:0] rt_wb, rt_wb_odd;
   logic [6:0]   rt_addr_wb, rt_addr_wb_odd;
   logic         reg_write_wb, reg_write_wb_odd;

   reg_fetch_even #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .valid_dec(valid_dec), .op_dec(op_dec),
      .format_dec(format_dec), .unit_dec(unit_dec), .imm_dec(imm_dec),
      .rt_addr_dec(rt_addr_dec), .ra_addr_dec(ra_addr_dec),
      .rb_addr_dec(rb_addr_dec), .rc_addr_dec(rc_addr_dec),
      .ra_use_dec(ra_use_dec), .rb_use_dec(rb_use_dec), .rc_use_dec(rc_use_dec),
      .reg_write_dec(reg_write_dec), .stall(stall), .op(op), .format(format),
      .unit(unit), .rt_addr(rt_addr), .ra(ra), .rb(rb), .rc(rc), .imm(imm),
      .reg_write(reg_write), .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb),
      .reg_write_wb(reg_write_wb), .rt_wb_odd(rt_wb_odd),
      .rt_addr_wb_odd(rt_addr_wb_odd), .reg_write_wb_odd(reg_write_wb_odd)
   );

   always #5 clk = ~clk;

   // Reference state: architectural register values and issued writers with their issue cycle.
   typedef struct { int cyc; logic [6:0] rt; logic wr; } flight_t;
   logic [127:0] mrf [128];
   flight_t      fl [$];
   int           cyc = 0;
   int           tests = 0;
   int           fails = 0;
   logic         last_stall = 1'b0;
   logic         obs_stall;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 128; i++) mrf[i] = '0;
      fl.delete();
   endtask

   function automatic logic uses(input logic [6:0] a);
      return (ra_use_dec && ra_addr_dec == a) || (rb_use_dec && rb_addr_dec == a) ||
             (rc_use_dec && rc_addr_dec == a);
   endfunction

   // A writer blocks readers until it reaches its writeback cycle (age DEPTH);
   // with forwarding, the writeback cycle itself is already safe.
   function automatic logic model_stall();
      int lim;
      lim = BYP ? DEPTH - 1 : DEPTH;
      if (!valid_dec) return 1'b0;
      foreach (fl[i]) begin
         if (fl[i].wr && (cyc - fl[i].cyc) >= 1 && (cyc - fl[i].cyc) <= lim && uses(fl[i].rt))
            return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [127:0] model_read(input logic [6:0] a);
      if (BYP && reg_write_wb && a == rt_addr_wb) return rt_wb;
      if (BYP && reg_write_wb_odd && a == rt_addr_wb_odd) return rt_wb_odd;
      return mrf[a];
   endfunction

   // Called just after a rising edge with this cycle's inputs already driven.
   task automatic step();
      logic st, iss;
      logic [127:0] ea, eb, ec;
      #1;
      st = model_stall();
      obs_stall = stall;
      chk("stall", stall, st);
      iss = valid_dec && !st;
      ea = iss ? model_read(ra_addr_dec) : '0;
      eb = iss ? model_read(rb_addr_dec) : '0;
      ec = iss ? model_read(rc_addr_dec) : '0;
      @(posedge clk);
      if (reg_write_wb_odd) mrf[rt_addr_wb_odd] = rt_wb_odd;
      if (reg_write_wb)     mrf[rt_addr_wb]     = rt_wb;
      if (iss) fl.push_back('{cyc, rt_addr_dec, reg_write_dec});
      cyc++;
      while (fl.size() > 0 && (cyc - fl[0].cyc) > DEPTH) void'(fl.pop_front());
      #1;
      chk("op",        op,        iss ? op_dec : 11'd0);
      chk("format",    format,    iss ? format_dec : 3'd0);
      chk("unit",      unit,      iss ? unit_dec : 2'd0);
      chk("rt_addr",   rt_addr,   iss ? rt_addr_dec : 7'd0);
      chk("imm",       imm,       iss ? imm_dec : 18'd0);
      chk("reg_write", reg_write, iss ? reg_write_dec : 1'b0);
      chk("ra", ra, ea);
      chk("rb", rb, eb);
      chk("rc", rc, ec);
      last_stall = st;
   endtask

   // Plays the even pipe: the writer issued DEPTH cycles ago writes back now.
   task automatic pipe_wb(input logic [127:0] data);
      reg_write_wb = 1'b0;
      rt_addr_wb   = 7'(($urandom));
      rt_wb        = data;
      foreach (fl[i]) begin
         if (cyc - fl[i].cyc == DEPTH) begin
            reg_write_wb = fl[i].wr;
            rt_addr_wb   = fl[i].rt;
         end
      end
   endtask

   task automatic set_dec(input logic v, input logic [10:0] o, input logic [6:0] rt,
                          input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                          input logic ua, input logic ub, input logic uc, input logic w);
      valid_dec = v; op_dec = o; rt_addr_dec = rt;
      ra_addr_dec = a; rb_addr_dec = b; rc_addr_dec = c;
      ra_use_dec = ua; rb_use_dec = ub; rc_use_dec = uc; reg_write_dec = w;
      format_dec = 3'(o); unit_dec = 2'(o >> 3); imm_dec = {7'd0, o};
   endtask

   task automatic no_wb();
      reg_write_wb = 1'b0; rt_addr_wb = '0; rt_wb = '0;
      reg_write_wb_odd = 1'b0; rt_addr_wb_odd = '0; rt_wb_odd = '0;
   endtask

   // Producer writes rt, consumer reads it on ra the very next cycle.
   task automatic dep_test(input string tag, input logic [6:0] rt, input logic [127:0] data);
      int n;
      no_wb();
      set_dec(1'b1, 11'h2c4, rt, 7'd1, 7'd2, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      step();
      set_dec(1'b1, 11'h2c5, 7'd20, rt, 7'd2, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      n = 0;
      pipe_wb(data);
      step();
      while (obs_stall && n < 20) begin
         n++;
         pipe_wb(data);
         step();
      end
      chk({tag, "_stall_cycles"}, 128'(n), BYP ? 128'(DEPTH - 1) : 128'(DEPTH));
      chk({tag, "_ra"}, ra, data);
      no_wb();
      set_dec(1'b0, 11'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      model_reset();
      reset = 1'b1;
      no_wb();
      set_dec(1'b0, 11'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("rst_stall", stall, 1'b0);
      chk("rst_op", op, 11'd0);
      chk("rst_ra", ra, 128'd0);
      chk("rst_rt_addr", rt_addr, 7'd0);
      chk("rst_reg_write", reg_write, 1'b0);

      // Read $r3 with nothing written.
      set_dec(1'b1, 11'h011, 7'd5, 7'd3, 7'd3, 7'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      chk("r3_empty", ra, 128'd0);

      dep_test("wb_r3", 7'd3, 128'h25);
      dep_test("mpy_fa", 7'd4, 128'hdead_beef_0000_0004);

      // Even and odd collide on $r9: even value must stick.
      reg_write_wb = 1'b1; rt_addr_wb = 7'd9; rt_wb = 128'd1;
      reg_write_wb_odd = 1'b1; rt_addr_wb_odd = 7'd9; rt_wb_odd = 128'd2;
      step();
      no_wb();
      set_dec(1'b1, 11'h033, 7'd10, 7'd9, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      chk("r9_even_wins", ra, 128'd1);

      // Unused source matching an in-flight writer must not stall.
      set_dec(1'b1, 11'h040, 7'd5, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      set_dec(1'b1, 11'h041, 7'd6, 7'd1, 7'd5, 7'd2, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      chk("unused_rb_no_stall", obs_stall, 1'b0);

      // Reset asserted while stalled clears everything without a clock edge.
      set_dec(1'b1, 11'h155, 7'd6, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      set_dec(1'b1, 11'h156, 7'd7, 7'd6, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      #1;
      chk("pre_rst_stall", stall, 1'b1);
      reset = 1'b1;
      #1;
      chk("async_rst_stall", stall, 1'b0);
      chk("async_rst_op", op, 11'd0);
      chk("async_rst_rt_addr", rt_addr, 7'd0);
      chk("async_rst_reg_write", reg_write, 1'b0);
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      step();
      chk("post_rst_issue_op", op, 11'h156);

      // Randomized traffic over a small register window to provoke hazards.
      for (int k = 0; k < 400; k++) begin
         if (!last_stall) begin
            set_dec($urandom_range(0, 9) < 8, 11'($urandom), 7'($urandom_range(0, 7)),
                    7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
                    7'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                    1'($urandom), $urandom_range(0, 3) != 0);
         end
         pipe_wb({$urandom, $urandom, $urandom, $urandom});
         reg_write_wb_odd = $urandom_range(0, 3) == 0;
         rt_addr_wb_odd   = 7'($urandom_range(0, 7));
         rt_wb_odd        = {$urandom, $urandom, $urandom, $urandom};
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
